// File: rtl/lfsr_seq_checker.sv
// Purpose: BIST monitor for a 3-bit Galois LFSR stream. Locks a local predictor
//          onto the incoming words, then flags every word that deviates from it.
// Latency: all outputs registered; they reflect the sample taken on the previous edge.
// Backpressure: none; the checker always accepts din when din_vld is high.
// Ports:
//   clk       rising-edge clock
//   arst_n    asynchronous active-low reset
//   din       3-bit LFSR word from the upstream stage
//   din_vld   din is sampled this cycle when high
//   clr       synchronous clear of err_cnt and lock state (wins over din_vld)
//   locked    high while the predictor is locked (CHECK)
//   err       one-cycle pulse per mismatching word while locked
//   err_cnt   saturating mismatch count
//   sync_loss one-cycle pulse when lock is dropped
module lfsr_seq_checker #(
  parameter int LOCK_N = 3,
  parameter int MISS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [2:0]       din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sync_loss
);

  typedef enum logic {HUNT, CHECK} state_t;

  localparam logic [2:0] LOCK_C = 3'(LOCK_N);
  localparam logic [2:0] MISS_C = 3'(MISS_N);

  state_t     state;
  logic       have_seed;
  logic [2:0] exp;
  logic [2:0] match_cnt;
  logic [2:0] miss_cnt;

  // Next state of the LFSR; 000 is the lock-up state and maps to itself.
  function automatic logic [2:0] lfsr_next(input logic [2:0] s);
    return {s[2] ^ s[1], s[0], s[2]};
  endfunction

  logic [2:0] match_inc;
  logic [2:0] miss_inc;
  assign match_inc = match_cnt + 3'd1;
  assign miss_inc  = miss_cnt + 3'd1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= HUNT;
      have_seed <= 1'b0;
      exp       <= 3'b000;
      match_cnt <= 3'd0;
      miss_cnt  <= 3'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      sync_loss <= 1'b0;
    end else begin
      // Pulses default low; only a valid sample can raise them.
      err       <= 1'b0;
      sync_loss <= 1'b0;
      if (clr) begin
        state     <= HUNT;
        have_seed <= 1'b0;
        match_cnt <= 3'd0;
        miss_cnt  <= 3'd0;
        locked    <= 1'b0;
        err_cnt   <= '0;
      end else if (din_vld) begin
        case (state)
          HUNT: begin
            if (!have_seed) begin
              // A zero word cannot seed the predictor: it would stick at 000.
              if (din != 3'b000) begin
                exp       <= lfsr_next(din);
                have_seed <= 1'b1;
                match_cnt <= 3'd0;
              end
            end else if (din == exp) begin
              exp <= lfsr_next(din);
              if (match_inc == LOCK_C) begin
                state     <= CHECK;
                locked    <= 1'b1;
                miss_cnt  <= 3'd0;
                match_cnt <= 3'd0;
              end else begin
                match_cnt <= match_inc;
              end
            end else if (din != 3'b000) begin
              exp       <= lfsr_next(din);
              match_cnt <= 3'd0;
            end else begin
              have_seed <= 1'b0;
              match_cnt <= 3'd0;
            end
          end

          CHECK: begin
            // Predictor free-runs from its own state, so a single corrupted
            // word costs exactly one error instead of two.
            exp <= lfsr_next(exp);
            if (din == exp) begin
              miss_cnt <= 3'd0;
            end else begin
              err <= 1'b1;
              if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + 1'b1;
              end
              if (miss_inc == MISS_C) begin
                state     <= HUNT;
                locked    <= 1'b0;
                sync_loss <= 1'b1;
                have_seed <= 1'b0;
                match_cnt <= 3'd0;
                miss_cnt  <= 3'd0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end
          end

          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
module tb_lfsr_seq_checker;

  logic       clk;
  logic       arst_n;
  logic [2:0] din;
  logic       din_vld;
  logic       clr;

  logic       locked, err, sync_loss;
  logic [7:0] err_cnt;
  logic       locked2, err2, sync_loss2;
  logic [1:0] err_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] w;
  int         errs;

  lfsr_seq_checker #(.LOCK_N(3), .MISS_N(2), .CNT_W(8)) u_dut (
    .clk(clk), .arst_n(arst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .sync_loss(sync_loss)
  );

  lfsr_seq_checker #(.LOCK_N(3), .MISS_N(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .arst_n(arst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2), .sync_loss(sync_loss2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] nx(input logic [2:0] s);
    return {s[2] ^ s[1], s[0], s[2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 ns after the edge.
  task automatic cyc(input logic v, input logic [2:0] d, input logic c);
    @(negedge clk);
    din     = d;
    din_vld = v;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  // Send the correct next word of the stream.
  task automatic good();
    cyc(1'b1, w, 1'b0);
    errs += int'(err);
    w = nx(w);
  endtask

  initial begin
    arst_n  = 1'b1;
    din     = 3'b000;
    din_vld = 1'b0;
    clr     = 1'b0;
    errs    = 0;
    #2 arst_n = 1'b0;
    #5;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sync_loss", sync_loss, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Lock from 001: seed + 3 matches, locked visible after the 4th word.
    w = 3'b001;
    good(); good(); good();
    chk("lock_not_yet", locked, 0);
    good();
    chk("lock_after_4", locked, 1);
    errs = 0;
    for (int i = 0; i < 20; i++) good();
    chk("clean_err_pulses", errs, 0);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_locked", locked, 1);

    // Replace one 111 with 000.
    for (int i = 0; i < 7 && w != 3'b111; i++) good();
    cyc(1'b1, 3'b000, 1'b0);
    w = nx(w);
    chk("zero_err", err, 1);
    chk("zero_err_cnt", err_cnt, 1);
    chk("zero_locked", locked, 1);
    good();
    chk("zero_recover_err", err, 0);
    chk("zero_recover_sl", sync_loss, 0);
    // A further isolated miss must not drop lock if miss_cnt was cleared.
    cyc(1'b1, nx(w), 1'b0);
    w = nx(w);
    chk("iso_err_cnt", err_cnt, 2);
    chk("iso_sync_loss", sync_loss, 0);
    good();
    chk("iso_locked", locked, 1);

    // Phase jump: stream skips two words.
    w = nx(nx(w));
    good();
    chk("jump1_err", err, 1);
    chk("jump1_sl", sync_loss, 0);
    good();
    chk("jump2_err", err, 1);
    chk("jump2_err_cnt", err_cnt, 4);
    chk("jump2_sync_loss", sync_loss, 1);
    chk("jump2_locked", locked, 0);
    chk("jump2_cnt2_sat", err_cnt2, 3);
    good();
    chk("sl_pulse_end", sync_loss, 0);
    good(); good();
    chk("relock_not_yet", locked, 0);
    good();
    chk("relock", locked, 1);

    // din_vld toggling: invalid cycles carry garbage and must not advance.
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      good();
      cyc(1'b0, 3'b000, 1'b0);
      errs += int'(err);
    end
    chk("toggle_errs", errs, 0);
    chk("toggle_err_cnt", err_cnt, 4);
    chk("toggle_locked", locked, 1);

    // clr with a simultaneous mismatching valid word.
    cyc(1'b1, nx(w), 1'b1);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_err_cnt2", err_cnt2, 0);
    chk("clr_locked", locked, 0);
    chk("clr_err", err, 0);

    // Relock, then 5 isolated mismatches; 2-bit counter saturates at 3.
    good(); good(); good(); good();
    chk("clr_relock", locked, 1);
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, nx(w), 1'b0);
      errs += int'(err);
      w = nx(w);
      good();
    end
    chk("sat_err_pulses", errs, 5);
    chk("sat_err_cnt8", err_cnt, 5);
    chk("sat_err_cnt2", err_cnt2, 3);
    chk("sat_locked", locked2, 1);

    // Asynchronous reset mid-lock clears outputs before any clock edge.
    cyc(1'b1, nx(w), 1'b0);
    w = nx(w);
    chk("pre_rst_err", err, 1);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err", err, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_sync_loss", sync_loss, 0);
    #2 arst_n = 1'b1;
    good(); good(); good();
    chk("arst_relock_not_yet", locked, 0);
    good();
    chk("arst_relock", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
